pop_init_gen: RTL and testbench
===============================

# pop_init_gen

Parametrised initial-population generator for the genetic engine. On a start pulse it fills a flat population vector of NUM_IND individuals × IND_BITS bits from an internal xorshift32 generator, one chunk per cycle, with a selectable fill mode. Mode 3 gives a biased, sparse fill. It sits ahead of the fitness/selection stages. It exports the final generator state so downstream random blocks can continue the same sequence.

## Interface
- NUM_IND, default 30: number of individuals.
- IND_BITS, default 250: bits per individual.
- CHUNK_BITS, default 8: bits appended per fill step, 1..32.
- Derived: TOTAL = NUM_IND*IND_BITS; NUM_CHUNKS = ceil(TOTAL/CHUNK_BITS); a 10/16-bit counter sized $clog2(NUM_CHUNKS+1).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled request, accepted only in IDLE.
- seed  in  32  PRNG seed, latched on the cycle start is accepted.
- mode  in  2  fill mode, latched with seed: 0 random, 1 all-zero, 2 all-ones, 3 biased random (AND of two draws, ~25% ones).
- population  out  TOTAL  generated population, registered.
- busy  out  1  high in LOAD and FILL.
- done  out  1  one-cycle pulse in DONE.
- prng_state  out  32  current generator state, registered.

## Operation
- States: IDLE, LOAD, FILL, DONE.
- IDLE -> LOAD when start=1.
- LOAD -> FILL always.
- FILL -> DONE after the last chunk is written.
- DONE -> IDLE always.
- Start in any state other than IDLE is ignored.
- LOAD:
  - prng_state <= (seed==0) ? 32'h1 : seed.
  - Internal shift register cleared to 0.
  - Chunk counter cleared to 0.
  - mode latched.
- PRNG step, combinational from state x:
  - t = x ^ (x<<13);
  - t = t ^ (t>>17);
  - next = t ^ (t<<5).
  - All arithmetic is 32-bit, truncating.
- Draw = low CHUNK_BITS of next. Every draw updates prng_state <= next.
- FILL, modes 0/1/2: one draw per cycle.
  - Chunk = draw (mode 0), all-zeros (mode 1) or all-ones (mode 2).
  - The PRNG advances in every mode, so prng_state on exit is mode-independent except for mode 3.
- FILL, mode 3: two draws per chunk on consecutive cycles.
  - First cycle holds draw A in a register.
  - Second cycle writes chunk = A & B.
- Write action:
  - shreg <= (shreg << CHUNK_BITS) | chunk, on a NUM_CHUNKS*CHUNK_BITS-bit register.
  - Counter += 1.
  - The first chunk ends up most significant. Surplus top bits beyond TOTAL are discarded.
- The cycle that writes chunk NUM_CHUNKS-1 moves the FSM to DONE and loads population <= shreg_next[TOTAL-1:0].
- population changes only on that cycle and on reset. It holds its previous value while a new fill runs.
- prng_state holds its value in IDLE/DONE.

## Timing
- Reset values:
  - state IDLE.
  - population 0.
  - prng_state 32'h1.
  - busy 0, done 0.
  - Counter 0, internal shift register 0.
- rst=1 at any point, including mid-FILL, aborts on that edge to reset values. No done pulse is produced.
- Latency, start sampled at edge E:
  - LOAD during cycle E..E+1.
  - Modes 0/1/2: done is high in the cycle after edge E+1+NUM_CHUNKS.
  - Mode 3: done is high in the cycle after edge E+1+2*NUM_CHUNKS.
  - population is valid in the same cycle that done is high.
- busy=1 from the cycle after the accepting edge until DONE. busy=0 in DONE.
- start held high continuously: a new run is accepted on the edge leaving IDLE after DONE. Minimum issue interval is NUM_CHUNKS+3 cycles (modes 0/1/2).
- Boundaries:
  - seed 0 substitutes 1.
  - NUM_CHUNKS=1 gives exactly one FILL cycle.
  - CHUNK_BITS=32 uses the full state.
  - The counter never wraps within a run.

## Test plan
- NUM_IND=2, IND_BITS=8, CHUNK_BITS=8, seed=1, mode 0 -> draws 0x21 then 0x01. population=16'h2101 and prng_state=32'h04080601 when done is high; done is 4 cycles after the start edge; busy high for 3 cycles.
- Same configuration, seed=0 -> identical result to seed=1.
- Same configuration, modes 1 and 2 -> population 16'h0000 / 16'hFFFF, prng_state=32'h04080601 in both. Mode 3 -> done after 6 cycles, population = (0x21&0x01)<<8 | (draw3 & draw4) per the reference model.
- Default parameters, random seed -> population matches a bench xorshift32 model bit-for-bit across 7500 bits, with done 940 cycles after start. A second start during FILL is ignored and the result is unchanged.
- rst asserted mid-FILL -> the next cycle shows population=0, busy=0, prng_state=1, and no done pulse. A fresh start then completes with the correct value.
- IND_BITS=5, NUM_IND=1, CHUNK_BITS=8, seed=1 -> population=5'h01 (low 5 bits of 0x21). One FILL cycle; done 3 cycles after start.

Source files
------------

// File: rtl/pop_init_gen.sv
// Purpose: fills a NUM_IND x IND_BITS population from an xorshift32 stream, one chunk per write.
// Latency: done is high NUM_CHUNKS+2 cycles after start (2*NUM_CHUNKS+2 in biased mode 3).
// Backpressure: none; start is ignored unless IDLE, busy marks LOAD/FILL.
// Ports: clk, rst (sync, active-high); start/seed/mode request a run;
//        population (registered result), busy, done (1-cycle pulse), prng_state (generator state).
module pop_init_gen #(
  parameter int NUM_IND    = 30,
  parameter int IND_BITS   = 250,
  parameter int CHUNK_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [31:0]                  seed,
  input  logic [1:0]                   mode,
  output logic [NUM_IND*IND_BITS-1:0]  population,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  prng_state
);

  localparam int TOTAL      = NUM_IND * IND_BITS;
  localparam int NUM_CHUNKS = (TOTAL + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int SHW        = NUM_CHUNKS * CHUNK_BITS;
  localparam int CW         = $clog2(NUM_CHUNKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [SHW-1:0]        shreg;
  logic [SHW-1:0]        shreg_next;
  logic [31:0]           seed_q;
  logic [1:0]            mode_q;
  logic                  phase;      // mode 3: 0 = draw A pending, 1 = draw B / write
  logic [CHUNK_BITS-1:0] draw_a;
  logic [CHUNK_BITS-1:0] draw;
  logic [CHUNK_BITS-1:0] chunk;
  logic [31:0]           t0;
  logic [31:0]           t1;
  logic [31:0]           prng_next;
  logic                  write_en;
  logic                  last_chunk;

  // xorshift32 step from the current registered state
  always_comb begin
    t0        = prng_state ^ (prng_state << 13);
    t1        = t0 ^ (t0 >> 17);
    prng_next = t1 ^ (t1 << 5);
    draw      = prng_next[CHUNK_BITS-1:0];
  end

  always_comb begin
    chunk = draw;
    case (mode_q)
      2'd1:    chunk = '0;
      2'd2:    chunk = '1;
      2'd3:    chunk = draw_a & draw;
      default: chunk = draw;
    endcase
  end

  // Mode 3 spends two cycles per chunk; only the second one writes.
  assign write_en   = (state == S_FILL) && ((mode_q != 2'd3) || phase);
  assign last_chunk = (cnt == CW'(NUM_CHUNKS - 1));
  // First chunk drifts to the top; bits above TOTAL fall off at the final load.
  assign shreg_next = (shreg << CHUNK_BITS) | SHW'(chunk);

  assign busy = (state == S_LOAD) || (state == S_FILL);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      population <= '0;
      prng_state <= 32'h1;
      cnt        <= '0;
      shreg      <= '0;
      seed_q     <= '0;
      mode_q     <= '0;
      phase      <= 1'b0;
      draw_a     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            seed_q <= seed;
            mode_q <= mode;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          // a zero seed would lock xorshift at zero forever
          prng_state <= (seed_q == 32'h0) ? 32'h1 : seed_q;
          shreg      <= '0;
          cnt        <= '0;
          phase      <= 1'b0;
          state      <= S_FILL;
        end
        S_FILL: begin
          prng_state <= prng_next;
          if (mode_q == 2'd3) begin
            phase <= ~phase;
            if (!phase) draw_a <= draw;
          end
          if (write_en) begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
            if (last_chunk) begin
              population <= shreg_next[TOTAL-1:0];
              state      <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pop_init_gen.sv
module tb_pop_init_gen;

  localparam int PW = 7500;  // widest population among the instances below
  localparam int NI_N = 4;

  // instance 0: 2x8/8, 1: defaults, 2: 1x5/8, 3: 3x20/32
  function automatic int f_ni(input int g);
    case (g) 0: return 2; 1: return 30; 2: return 1; default: return 3; endcase
  endfunction
  function automatic int f_ib(input int g);
    case (g) 0: return 8; 1: return 250; 2: return 5; default: return 20; endcase
  endfunction
  function automatic int f_cb(input int g);
    case (g) 0: return 8; 1: return 8; 2: return 8; default: return 32; endcase
  endfunction

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NI_N-1:0]   start = '0;
  logic [31:0]       seed [NI_N];
  logic [1:0]        mode [NI_N];
  logic [NI_N-1:0]   busy;
  logic [NI_N-1:0]   done;
  logic [31:0]       st_o [NI_N];
  logic [PW-1:0]     pop_o [NI_N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI_N; g++) begin : g_dut
    localparam int NI = f_ni(g);
    localparam int IB = f_ib(g);
    localparam int CB = f_cb(g);
    logic [NI*IB-1:0] p;
    pop_init_gen #(.NUM_IND(NI), .IND_BITS(IB), .CHUNK_BITS(CB)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .seed(seed[g]), .mode(mode[g]),
      .population(p), .busy(busy[g]), .done(done[g]), .prng_state(st_o[g])
    );
    assign pop_o[g] = PW'(p);
  end

  typedef struct {
    int            inst;
    logic [PW-1:0] pop;
    logic [31:0]   st;
    int            lat;
    int            bcnt;
    int            acc;
  } exp_t;

  exp_t          sbq [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            bcnt [NI_N];
  logic [PW-1:0] last_pop [NI_N];

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  // Reference: build the ordered bit stream of all chunks, first chunk first;
  // the population is the last TOTAL bits of that stream.
  function automatic void model(input int g, input logic [31:0] sd, input logic [1:0] md,
                                output logic [PW-1:0] pop, output logic [31:0] st, output int nc);
    int tot, cb, shw;
    logic [31:0] x, a, c;
    bit stream [$];
    tot = f_ni(g) * f_ib(g);
    cb  = f_cb(g);
    nc  = (tot + cb - 1) / cb;
    shw = nc * cb;
    x   = (sd == 0) ? 32'h1 : sd;
    for (int k = 0; k < nc; k++) begin
      x = xs32(x);
      case (md)
        2'd0: c = x;
        2'd1: c = 32'h0;
        2'd2: c = 32'hFFFF_FFFF;
        default: begin a = x; x = xs32(x); c = a & x; end
      endcase
      for (int b = cb - 1; b >= 0; b--) stream.push_back(c[b]);
    end
    pop = '0;
    for (int j = 0; j < tot; j++) pop[tot-1-j] = stream[shw-tot+j];
    st = x;
  endfunction

  // Monitor: pops and compares whenever a done pulse is presented.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI_N; i++) begin bcnt[i] = 0; last_pop[i] = '0; end
    end else begin
      for (int i = 0; i < NI_N; i++) begin
        if (busy[i]) begin
          bcnt[i]++;
          chk(pop_o[i] == last_pop[i], "pop_hold_while_busy", pop_o[i][63:0], last_pop[i][63:0]);
        end
        if (done[i]) begin
          chk(sbq.size() != 0 && sbq[0].inst == i, "unexpected_done", 64'(i), 64'(sbq.size()));
          if (sbq.size() != 0 && sbq[0].inst == i) begin
            exp_t e;
            e = sbq.pop_front();
            chk(pop_o[i] == e.pop, "population", pop_o[i][63:0], e.pop[63:0]);
            chk(st_o[i] == e.st, "prng_state", 64'(st_o[i]), 64'(e.st));
            // +1: the edge after this negedge is the one that samples done
            chk(cyc - e.acc + 1 == e.lat, "done_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            chk(bcnt[i] == e.bcnt, "busy_cycles", 64'(bcnt[i]), 64'(e.bcnt));
          end
          last_pop[i] = pop_o[i];
          bcnt[i] = 0;
        end
      end
    end
  end

  task automatic run(input int g, input logic [31:0] sd, input logic [1:0] md, input int poke);
    exp_t e;
    int nc, limit;
    model(g, sd, md, e.pop, e.st, nc);
    e.inst = g;
    e.lat  = (md == 2'd3) ? 2 * nc + 2 : nc + 2;
    e.bcnt = (md == 2'd3) ? 2 * nc + 1 : nc + 1;
    limit  = 2 * nc + 20;
    @(negedge clk);
    seed[g] = sd; mode[g] = md; start[g] = 1'b1;
    @(posedge clk); #1;
    e.acc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    start[g] = 1'b0;
    for (int k = 0; k < limit && sbq.size() != 0; k++) begin
      @(negedge clk);
      start[g] = (poke != 0 && k == poke);
    end
    start[g] = 1'b0;
    chk(sbq.size() == 0, "done_timeout", 64'(sbq.size()), 64'd0);
    sbq.delete();
    @(posedge clk);  // DONE -> IDLE
  endtask

  initial begin
    logic [31:0] rs;
    for (int i = 0; i < NI_N; i++) begin seed[i] = '0; mode[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI_N; i++) begin
      chk(pop_o[i] == '0, "reset_population", pop_o[i][63:0], 64'd0);
      chk(st_o[i] == 32'h1, "reset_prng_state", 64'(st_o[i]), 64'd1);
      chk(busy[i] == 1'b0, "reset_busy", 64'(busy[i]), 64'd0);
      chk(done[i] == 1'b0, "reset_done", 64'(done[i]), 64'd0);
    end

    // small instance: hand-derived anchors plus mode variants
    run(0, 32'h1, 2'd0, 0);
    @(negedge clk);
    chk(pop_o[0][15:0] == 16'h2101, "anchor_pop_seed1", 64'(pop_o[0][15:0]), 64'h2101);
    chk(st_o[0] == 32'h0408_0601, "anchor_state_seed1", 64'(st_o[0]), 64'h04080601);
    run(0, 32'h0, 2'd0, 0);
    @(negedge clk);
    chk(pop_o[0][15:0] == 16'h2101, "anchor_pop_seed0", 64'(pop_o[0][15:0]), 64'h2101);
    run(0, 32'h1, 2'd1, 0);
    @(negedge clk);
    chk(pop_o[0][15:0] == 16'h0000, "anchor_pop_mode1", 64'(pop_o[0][15:0]), 64'h0);
    chk(st_o[0] == 32'h0408_0601, "anchor_state_mode1", 64'(st_o[0]), 64'h04080601);
    run(0, 32'h1, 2'd2, 0);
    @(negedge clk);
    chk(pop_o[0][15:0] == 16'hFFFF, "anchor_pop_mode2", 64'(pop_o[0][15:0]), 64'hFFFF);
    run(0, 32'h1, 2'd3, 0);

    // single-chunk instance with truncated top bits
    run(2, 32'h1, 2'd0, 0);
    @(negedge clk);
    chk(pop_o[2][4:0] == 5'h01, "anchor_pop_5bit", 64'(pop_o[2][4:0]), 64'h01);

    // default instance: random seed with an ignored start mid-FILL, then mode 3
    rs = $urandom;
    run(1, rs, 2'd0, 100);
    run(1, $urandom, 2'd3, 0);

    // abort mid-FILL
    @(negedge clk);
    seed[1] = $urandom; mode[1] = 2'd0; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(pop_o[1] == '0, "abort_population", pop_o[1][63:0], 64'd0);
    chk(busy[1] == 1'b0, "abort_busy", 64'(busy[1]), 64'd0);
    chk(st_o[1] == 32'h1, "abort_prng_state", 64'(st_o[1]), 64'd1);
    rst = 1'b0;
    repeat (950) @(negedge clk);  // any done here is flagged as unexpected
    run(1, rs, 2'($urandom_range(0, 3)), 0);

    // randomized runs on the small instances
    for (int r = 0; r < 16; r++) begin
      int g;
      g  = (r % 3 == 0) ? 0 : (r % 3 == 1) ? 2 : 3;
      rs = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run(g, rs, 2'($urandom_range(0, 3)), 0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
